demux1x2_16bit: RTL and testbench
=================================

DEMUX1X2_16BIT -- requirements
Module: demux1x2_16bit

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter CNTW, default 8, width of each per-destination transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  source presents a word.
REQ-006 in_sel  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
REQ-007 in_data  input  WIDTH  word to route.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 out0_valid / out1_valid  output  1  channel holds a word.
REQ-010 out0_data / out1_data  output  WIDTH  held word per channel.
REQ-011 out0_ready / out1_ready  input  1  sink takes the channel word this cycle.
REQ-012 cnt0 / cnt1  output  CNTW  count of words delivered per channel.

Function
REQ-013 Each channel SHALL be a two-state machine: EMPTY (valid=0) and FULL (valid=1); the two channels are independent.
REQ-014 Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer on channel k when outk_valid=1 and outk_ready=1.
REQ-015 in_ready SHALL equal (selected channel EMPTY) OR (selected channel outk_ready=1); it SHALL NOT depend on in_valid or in_data.
REQ-016 On input transfer to channel k, outk_data SHALL load in_data and the channel SHALL be FULL the next cycle (latency 1 cycle, no combinational in_data->outk_data path).
REQ-017 Channel k SHALL go FULL->EMPTY on an output transfer with no simultaneous input transfer to k.
REQ-018 Simultaneous output and input transfer on channel k SHALL leave it FULL with the new word (1 word/cycle sustained throughput).
REQ-019 While FULL and outk_ready=0, outk_data SHALL hold stable and outk_valid SHALL stay 1.
REQ-020 An input transfer to one channel SHALL NOT alter the state, data or counter of the other channel.
REQ-021 cntk SHALL increment by 1 per output transfer on channel k, wrapping from 2^CNTW-1 to 0 with no flag.
REQ-022 outk_data SHALL retain its last value after FULL->EMPTY; only outk_valid qualifies it.
REQ-023 in_sel and in_data SHALL be ignored when in_valid=0.

Reset
REQ-024 While rst=1, both channels SHALL be EMPTY, outk_data=0, cntk=0, asynchronously to clk.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-operation SHALL discard held words without counting them.

Structure
REQ-027 WIDTH and CNTW defaults and the EMPTY/FULL state encodings SHALL live in the shared datapath constants package.
REQ-028 One sub-module, demux_slot, SHALL implement a single channel (state, data register, counter) and be instantiated twice; the top holds only select decode and in_ready logic.

Verification
REQ-029 Reset release, in_valid=0 -> out0_valid=out1_valid=0, cnt0=cnt1=0, in_ready=1.
REQ-030 in_valid=1, in_sel=1, in_data=16'hBEEF, out1_ready=0 -> next cycle out1_valid=1, out1_data=16'hBEEF, out0_valid=0; following cycle in_sel=1 -> in_ready=0, data stays 16'hBEEF.
REQ-031 Channel 0 FULL with 16'h1234, out0_ready=1, in_valid=1, in_sel=0, in_data=16'h5678 -> in_ready=1, next cycle out0_valid=1, out0_data=16'h5678, cnt0 +1.
REQ-032 Channel 1 FULL and stalled, in_sel=0, in_data=16'h00A5 -> accepted, out0_data=16'h00A5 next cycle, channel 1 unchanged.
REQ-033 256 back-to-back words to channel 0 with out0_ready=1 -> cnt0 returns to 0, cnt1 stays 0.
REQ-034 Both channels FULL, rst pulsed mid-cycle -> outputs valid=0, data=0, counters 0 immediately without clock edge.

Source files
------------

// File: rtl/demux1x2_16bit_pkg.sv
// Shared datapath constants for the 1-to-2 demultiplexer: default widths,
// per-channel state encoding and the channel acceptance rule.
package demux1x2_16bit_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNTW_DEF  = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // A channel can take a word when it is empty or is being drained this cycle.
  function automatic logic slot_can_accept(input slot_state_e st, input logic out_ready);
    return (st == SLOT_EMPTY) || out_ready;
  endfunction

endpackage

// File: rtl/demux1x2_16bit_slot.sv
// One demultiplexer channel: a single-entry holding register with an
// EMPTY/FULL state and a wrapping count of words handed to the sink.
module demux_slot
  import demux1x2_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             out_ready,
  output logic             can_accept,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  cnt
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             out_xfer_s;

  // Next-state: a write always leaves the slot FULL, even while draining.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    out_xfer_s = (state_q == SLOT_FULL) && out_ready;
    if (wr_en) begin
      state_d = SLOT_FULL;
      data_d  = wr_data;
    end else if (out_xfer_s) begin
      state_d = SLOT_EMPTY;
    end else begin
      state_d = state_q;
    end
    if (out_xfer_s) begin
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state, held word and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNTW{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign can_accept = slot_can_accept(state_q, out_ready);
  assign out_valid  = (state_q == SLOT_FULL);
  assign out_data   = data_q;
  assign cnt        = cnt_q;

endmodule

// File: rtl/demux1x2_16bit.sv
// 1-to-2 demultiplexer with per-channel single-word buffering and delivery
// counters; the top only decodes the select and forms in_ready.
module demux1x2_16bit
  import demux1x2_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic acc0_s, acc1_s;
  logic wr0_s, wr1_s;

  // in_ready follows only the selected channel, never in_valid or in_data.
  always_comb begin
    in_ready = 1'b0;
    wr0_s    = 1'b0;
    wr1_s    = 1'b0;
    case (in_sel)
      1'b0:    in_ready = acc0_s;
      1'b1:    in_ready = acc1_s;
      default: in_ready = 1'b0;
    endcase
    if (in_valid && in_ready) begin
      wr0_s = (in_sel == 1'b0);
      wr1_s = (in_sel == 1'b1);
    end else begin
      wr0_s = 1'b0;
      wr1_s = 1'b0;
    end
  end

  demux_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr0_s),
    .wr_data    (in_data),
    .out_ready  (out0_ready),
    .can_accept (acc0_s),
    .out_valid  (out0_valid),
    .out_data   (out0_data),
    .cnt        (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr1_s),
    .wr_data    (in_data),
    .out_ready  (out1_ready),
    .can_accept (acc1_s),
    .out_valid  (out1_valid),
    .out_data   (out1_data),
    .cnt        (cnt1)
  );

endmodule

// File: tb/tb_demux1x2_16bit.sv
// Directed bench: expected words queue per channel at issue time, a monitor
// pops and compares them on every output handshake.
module tb_demux1x2_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sel = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic        out0_valid, out1_valid;
  logic [15:0] out0_data, out1_data;
  logic        out0_ready = 1'b0, out1_ready = 1'b0;
  logic [7:0]  cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  demux1x2_16bit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one input cycle; exp_acc is the hand-computed in_ready.
  task automatic send(input logic v, input logic sel, input logic [15:0] d,
                      input logic r0, input logic r1, input logic exp_acc);
    in_valid = v; in_sel = sel; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
    if (v && exp_acc) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out0_valid && out0_ready) begin
      if (q0.size() == 0) chk("ch0_unexpected", {16'd0, out0_data}, 32'hFFFF_FFFF);
      else chk("ch0_data", {16'd0, out0_data}, {16'd0, q0.pop_front()});
    end
    if (!rst && out1_valid && out1_ready) begin
      if (q1.size() == 0) chk("ch1_unexpected", {16'd0, out1_data}, 32'hFFFF_FFFF);
      else chk("ch1_data", {16'd0, out1_data}, {16'd0, q1.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    #3;
    chk("rst_v0", {31'd0, out0_valid}, 32'd0);
    chk("rst_v1", {31'd0, out1_valid}, 32'd0);
    chk("rst_cnt", {16'd0, cnt0, cnt1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_valids", {30'd0, out0_valid, out1_valid}, 32'd0);

    // Load channel 1 with BEEF while stalled, then check backpressure
    send(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    chk("c1_valid", {31'd0, out1_valid}, 32'd1);
    chk("c1_data", {16'd0, out1_data}, 32'h0000_BEEF);
    chk("c0_idle", {31'd0, out0_valid}, 32'd0);
    send(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    chk("c1_hold", {16'd0, out1_data}, 32'h0000_BEEF);

    // Channel 0 accepts while channel 1 is stalled
    send(1'b1, 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b1);
    chk("c0_a5", {16'd0, out0_data}, 32'h0000_00A5);
    chk("c1_untouched", {15'd0, out1_valid, out1_data}, 32'h0001_BEEF);

    // Replace-while-draining on channel 0
    send(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
    chk("c0_1234", {15'd0, out0_valid, out0_data}, 32'h0001_1234);
    chk("cnt0_1", {24'd0, cnt0}, 32'd1);
    send(1'b1, 1'b0, 16'h5678, 1'b1, 1'b0, 1'b1);
    chk("c0_5678", {15'd0, out0_valid, out0_data}, 32'h0001_5678);
    chk("cnt0_2", {24'd0, cnt0}, 32'd2);
    // Drain with garbage select/data while in_valid is low
    send(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("c0_empty_keep", {15'd0, out0_valid, out0_data}, 32'h0000_5678);
    chk("cnt0_3", {24'd0, cnt0}, 32'd3);
    chk("c1_still", {15'd0, out1_valid, out1_data}, 32'h0001_BEEF);
    send(1'b0, 1'b0, 16'hCAFE, 1'b0, 1'b1, 1'b1);
    chk("c1_drained", {31'd0, out1_valid}, 32'd0);
    chk("cnt1_1", {24'd0, cnt1}, 32'd1);

    // Both channels full, then an asynchronous reset pulse mid-cycle
    send(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    q0.delete(); q1.delete();
    #1;
    chk("arst_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
    chk("arst_data", {out0_data, out1_data}, 32'd0);
    chk("arst_cnt", {16'd0, cnt0, cnt1}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

    // 256 back-to-back words through channel 0 wrap its counter
    for (int i = 0; i < 256; i++) send(1'b1, 1'b0, 16'(i * 3 + 7), 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("wrap_cnt0", {24'd0, cnt0}, 32'd0);
    chk("wrap_cnt1", {24'd0, cnt1}, 32'd0);
    chk("wrap_empty", {30'd0, out0_valid, out1_valid}, 32'd0);
    @(negedge clk);
    chk("q_drained", q0.size() + q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
